rp_adc_decimator: RTL



---
 rtl/rp_adc_decimator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rp_adc_decimator.sv
// rp_adc_decimator: boxcar-average 2^k ADC samples per channel into a 2-deep valid/ready stream
module rp_adc_decimator #(
  parameter int DW       = 14,
  parameter int MAX_LOG2 = 10,
  parameter int CNT_W    = 16
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic [DW-1:0]    adc_dat_a_i,
  input  logic [DW-1:0]    adc_dat_b_i,
  input  logic             cfg_en_i,
  input  logic [3:0]       cfg_log2_dec_i,
  input  logic             cfg_clr_i,
  output logic [31:0]      m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             ovr_o,
  output logic [CNT_W-1:0] drop_cnt_o
);
  localparam int AW = DW + MAX_LOG2;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t                r_state;
  logic [3:0]            r_k;
  logic [MAX_LOG2-1:0]   r_cnt;
  logic signed [AW-1:0]  r_acc_a, r_acc_b;
  logic signed [DW-1:0]  r_s1_a, r_s1_b;
  logic                  r_res_vld;
  logic [31:0]           r_res;
  logic [31:0]           r_d0, r_d1;
  logic                  r_v0, r_v1;
  logic                  r_ovr;
  logic [CNT_W-1:0]      r_drop;
  logic [3:0]            w_k_cfg;
  logic [MAX_LOG2-1:0]   w_cnt_max;
  logic                  w_last;
  logic signed [AW-1:0]  w_sum_a, w_sum_b;
  logic signed [DW-1:0]  w_avg_a, w_avg_b;
  logic [31:0]           w_word;
  logic                  w_rd, w_drop;
  assign w_k_cfg   = (cfg_log2_dec_i > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : cfg_log2_dec_i;
  assign w_cnt_max = MAX_LOG2'((32'd1 << r_k) - 32'd1);
  assign w_last    = r_cnt == w_cnt_max;
  assign w_sum_a   = r_acc_a + {{MAX_LOG2{r_s1_a[DW-1]}}, r_s1_a};
  assign w_sum_b   = r_acc_b + {{MAX_LOG2{r_s1_b[DW-1]}}, r_s1_b};
  assign w_avg_a   = DW'(w_sum_a >>> r_k);
  assign w_avg_b   = DW'(w_sum_b >>> r_k);
  assign w_word    = {{(16-DW){w_avg_b[DW-1]}}, w_avg_b, {(16-DW){w_avg_a[DW-1]}}, w_avg_a};
  assign w_rd      = r_v0 & m_tready_i;
  assign w_drop    = r_res_vld & r_v1 & ~w_rd;
  assign m_tdata_o  = r_d0;
  assign m_tvalid_o = r_v0;
  assign ovr_o      = r_ovr;
  assign drop_cnt_o = r_drop;
  // S1: sample both channels every cycle regardless of state
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_s1_a <= '0;
      r_s1_b <= '0;
    end else begin
      r_s1_a <= adc_dat_a_i;
      r_s1_b <= adc_dat_b_i;
    end
  end
  // accumulate 2^k samples; k only changes at enable or at a block boundary
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_cnt     <= '0;
      r_acc_a   <= '0;
      r_acc_b   <= '0;
      r_res_vld <= 1'b0;
      r_res     <= '0;
    end else begin
      r_res_vld <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt   <= '0;
        r_acc_a <= '0;
        r_acc_b <= '0;
        if (cfg_en_i) begin
          r_state <= ACCUM;
          r_k     <= w_k_cfg;
        end
      end else if (!cfg_en_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_acc_a <= '0;
        r_acc_b <= '0;
      end else if (w_last) begin
        r_cnt     <= '0;
        r_acc_a   <= '0;
        r_acc_b   <= '0;
        r_k       <= w_k_cfg;
        r_res_vld <= 1'b1;
        r_res     <= w_word;
      end else begin
        r_cnt   <= r_cnt + MAX_LOG2'(1);
        r_acc_a <= w_sum_a;
        r_acc_b <= w_sum_b;
      end
    end
  end
  // 2-entry FIFO, head in r_d0; a read on a full FIFO makes room for a same-cycle write
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_d0 <= '0;
      r_d1 <= '0;
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (w_rd) begin
      r_d0 <= r_v1 ? r_d1 : r_res;
      r_d1 <= r_res;
      r_v0 <= r_v1 | r_res_vld;
      r_v1 <= r_v1 & r_res_vld;
    end else if (r_res_vld & ~r_v0) begin
      r_d0 <= r_res;
      r_v0 <= 1'b1;
    end else if (r_res_vld & ~r_v1) begin
      r_d1 <= r_res;
      r_v1 <= 1'b1;
    end
  end
  // drop accounting; a drop in the same cycle as a clear is applied after the clear
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_ovr  <= 1'b0;
      r_drop <= '0;
    end else if (cfg_clr_i) begin
      r_ovr  <= w_drop;
      r_drop <= CNT_W'(w_drop);
    end else if (w_drop) begin
      r_ovr  <= 1'b1;
      r_drop <= (&r_drop) ? r_drop : r_drop + CNT_W'(1);
    end
  end
endmodule
